// File: rtl/decode_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_pkg
// Brief    : Shared types, opcode constants and immediate generator for the
//            registered RISC-V decode stage.
// Revision : 1.0 - initial release
// ============================================================================
package decode_stage_pkg;

  // Widest supported datapath; packet fields are stored at this width.
  localparam int unsigned c_XLEN_MAX = 64;

  typedef logic [31:0] raw_instr_t;

  typedef enum logic [2:0] {
    instr_type_R  = 3'd0,
    instr_type_I  = 3'd1,
    instr_type_S  = 3'd2,
    instr_type_SB = 3'd3,
    instr_type_U  = 3'd4,
    instr_type_UJ = 3'd5
  } instr_type_t;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
  } decoded_instr_t;

  typedef struct packed {
    decoded_instr_t            instr;
    instr_type_t               itype;
    logic [c_XLEN_MAX-1:0]     imm;
    logic [c_XLEN_MAX-1:0]     pc;
    logic                      illegal;
  } decode_pkt_t;

  // Major opcodes, instr[6:2]
  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  // Sign-extended immediate for a format, with bits at and above 'width' cleared.
  function automatic logic [c_XLEN_MAX-1:0] imm_gen(input raw_instr_t instr,
                                                    input instr_type_t fmt,
                                                    input int unsigned width);
    logic [c_XLEN_MAX-1:0] v;
    logic [c_XLEN_MAX-1:0] mask;
    case (fmt)
      instr_type_I:  v = {{52{instr[31]}}, instr[31:20]};
      instr_type_S:  v = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      instr_type_SB: v = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      instr_type_UJ: v = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      instr_type_U:  v = {{32{instr[31]}}, instr[31:12], 12'b0};
      default:       v = '0;
    endcase
    mask = (width >= c_XLEN_MAX) ? '1 : ((64'd1 << width) - 64'd1);
    return v & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_if
// Brief    : Fetch-side and execute-side handshake bundle of the decode stage.
// Revision : 1.0 - initial release
// ============================================================================
interface decode_stage_if #(
  parameter int XLEN = 32
) ();
  import decode_stage_pkg::*;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  raw_instr_t        in_instr;
  logic [XLEN-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  decoded_instr_t    out_instr;
  instr_type_t       out_type;
  logic [XLEN-1:0]   out_imm;
  logic [XLEN-1:0]   out_pc;
  logic              out_illegal;
  logic [31:0]       decode_count;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_type, out_imm, out_pc,
           out_illegal, decode_count
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_type, out_imm, out_pc,
           out_illegal, decode_count
  );
endinterface
`default_nettype wire

// File: rtl/decode_stage_comb.sv
`default_nettype none
// ============================================================================
// Module   : decode_comb
// Brief    : Purely combinational raw instruction -> decode packet decoder.
// Revision : 1.0 - initial release
// ============================================================================
module decode_comb
  import decode_stage_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit ENABLE_M    = 1'b1,
  parameter bit ENABLE_PRIV = 1'b1
) (
  input  raw_instr_t      i_instr,
  input  logic [XLEN-1:0] i_pc,
  output decode_pkt_t     o_pkt
);

  logic [4:0]  w_opc;
  logic        w_known;
  logic        w_illegal;
  instr_type_t w_type;

  assign w_opc = i_instr[6:2];

  // Classify the major opcode into an instruction format.
  always_comb begin
    w_known = 1'b1;
    w_type  = instr_type_I;
    case (w_opc)
      OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: w_type = instr_type_I;
      OPC_AUIPC, OPC_LUI:                                       w_type = instr_type_U;
      OPC_STORE:                                                w_type = instr_type_S;
      OPC_OP:                                                   w_type = instr_type_R;
      OPC_BRANCH:                                               w_type = instr_type_SB;
      OPC_JAL:                                                  w_type = instr_type_UJ;
      default:                                                  w_known = 1'b0;
    endcase
  end

  assign w_illegal = (i_instr[1:0] != 2'b11) || !w_known
                   || (!ENABLE_M && (w_opc == OPC_OP) && (i_instr[31:25] == 7'b0000001))
                   || (!ENABLE_PRIV && (w_opc == OPC_SYSTEM));

  // Build the packet; fields unused by the format stay zero, illegal keeps only opcode.
  always_comb begin
    o_pkt              = '0;
    o_pkt.pc           = 64'(i_pc);
    o_pkt.instr.opcode = i_instr[6:0];
    o_pkt.illegal      = w_illegal;
    if (w_illegal) begin
      o_pkt.itype = instr_type_I;
    end else begin
      o_pkt.itype = w_type;
      o_pkt.imm   = imm_gen(i_instr, w_type, XLEN);
      case (w_type)
        instr_type_R: begin
          o_pkt.instr.rd     = i_instr[11:7];
          o_pkt.instr.rs1    = i_instr[19:15];
          o_pkt.instr.rs2    = i_instr[24:20];
          o_pkt.instr.funct3 = i_instr[14:12];
          o_pkt.instr.funct7 = i_instr[31:25];
        end
        instr_type_I: begin
          o_pkt.instr.rd     = i_instr[11:7];
          o_pkt.instr.rs1    = i_instr[19:15];
          o_pkt.instr.funct3 = i_instr[14:12];
        end
        instr_type_S, instr_type_SB: begin
          o_pkt.instr.rs1    = i_instr[19:15];
          o_pkt.instr.rs2    = i_instr[24:20];
          o_pkt.instr.funct3 = i_instr[14:12];
        end
        default: begin
          o_pkt.instr.rd     = i_instr[11:7];
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : Registered decode stage with 2-entry skid buffer, flush and
//            handshake counter.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit ENABLE_M    = 1'b1,
  parameter bit ENABLE_PRIV = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  decode_stage_if.slave  bus
);

  decode_pkt_t w_dec;
  decode_pkt_t r_main;
  decode_pkt_t r_skid;
  logic        r_main_valid;
  logic        r_skid_valid;
  logic [31:0] r_count;
  logic        w_in_ready;
  logic        w_accept;
  logic        w_out_hs;

  decode_comb #(
    .XLEN        (XLEN),
    .ENABLE_M    (ENABLE_M),
    .ENABLE_PRIV (ENABLE_PRIV)
  ) u_decode_comb (
    .i_instr (bus.in_instr),
    .i_pc    (bus.in_pc),
    .o_pkt   (w_dec)
  );

  // in_ready depends only on registered skid state, flush and rst.
  assign w_in_ready = !r_skid_valid && !bus.flush && !rst;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_out_hs   = r_main_valid && bus.out_ready;

  // Skid buffer: main feeds the outputs, skid catches an accept while main is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (bus.flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_main_valid || w_out_hs) begin
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_main       <= w_dec;
        r_main_valid <= 1'b1;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end

  // Count every output handshake, including one coincident with flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_out_hs) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = r_main_valid;
  assign bus.out_instr    = r_main.instr;
  assign bus.out_type     = r_main.itype;
  assign bus.out_imm      = r_main.imm[XLEN-1:0];
  assign bus.out_pc       = r_main.pc[XLEN-1:0];
  assign bus.out_illegal  = r_main.illegal;
  assign bus.decode_count = r_count;

  // Upper packet bits are always zero on narrow datapaths.
  if (XLEN < c_XLEN_MAX) begin : g_hi_unused
    logic w_unused_hi;
    assign w_unused_hi = ^{r_main.imm[c_XLEN_MAX-1:XLEN], r_main.pc[c_XLEN_MAX-1:XLEN]};
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Brief    : Scoreboard bench for decode_stage; a 32-bit full-featured and a
//            64-bit M/PRIV-disabled instance share one stimulus stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32)) if32 ();
  decode_stage_if #(.XLEN(64)) if64 ();

  assign if32.flush     = flush;
  assign if32.in_valid  = in_valid;
  assign if32.in_instr  = in_instr;
  assign if32.in_pc     = in_pc[31:0];
  assign if32.out_ready = out_ready;
  assign if64.flush     = flush;
  assign if64.in_valid  = in_valid;
  assign if64.in_instr  = in_instr;
  assign if64.in_pc     = in_pc;
  assign if64.out_ready = out_ready;

  decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .ENABLE_PRIV(1'b1)) dut32 (
    .clk(clk), .rst(rst), .bus(if32));
  decode_stage #(.XLEN(64), .ENABLE_M(1'b0), .ENABLE_PRIV(1'b0)) dut64 (
    .clk(clk), .rst(rst), .bus(if64));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] f;
    logic [2:0]  t;
    logic [63:0] imm;
    logic        ill;
  } exp_t;

  typedef struct {
    exp_t        e32;
    exp_t        e64;
    logic [63:0] pc;
  } sb_t;

  sb_t q[$];

  // Reference decoder written from the format table.
  function automatic exp_t model(input logic [31:0] w, input bit is64, input bit en_m, input bit en_priv);
    exp_t        r;
    bit          ok;
    instr_type_t t;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    ok = 1'b1;
    t  = instr_type_I;
    case (w[6:0])
      7'h03, 7'h0F, 7'h13, 7'h67, 7'h73: t = instr_type_I;
      7'h17, 7'h37:                      t = instr_type_U;
      7'h23:                             t = instr_type_S;
      7'h33:                             t = instr_type_R;
      7'h63:                             t = instr_type_SB;
      7'h6F:                             t = instr_type_UJ;
      default:                           ok = 1'b0;
    endcase
    if (!en_m && w[6:0] == 7'h33 && w[31:25] == 7'h01) ok = 1'b0;
    if (!en_priv && w[6:0] == 7'h73) ok = 1'b0;
    r.f = {w[6:0], 25'b0}; r.t = instr_type_I; r.imm = '0; r.ill = !ok;
    if (ok) begin
      rd = 0; rs1 = 0; rs2 = 0; f3 = 0; f7 = 0;
      r.t = t;
      case (t)
        instr_type_R:  begin rd = w[11:7]; rs1 = w[19:15]; rs2 = w[24:20]; f3 = w[14:12]; f7 = w[31:25]; end
        instr_type_I:  begin rd = w[11:7]; rs1 = w[19:15]; f3 = w[14:12]; end
        instr_type_S,
        instr_type_SB: begin rs1 = w[19:15]; rs2 = w[24:20]; f3 = w[14:12]; end
        default:       rd = w[11:7];
      endcase
      r.f = {w[6:0], rd, rs1, rs2, f3, f7};
      case (t)
        instr_type_I:  r.imm = 64'($signed(w[31:20]));
        instr_type_S:  r.imm = 64'($signed({w[31:25], w[11:7]}));
        instr_type_SB: r.imm = 64'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
        instr_type_UJ: r.imm = 64'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
        instr_type_U:  r.imm = 64'($signed({w[31:12], 12'h000}));
        default:       r.imm = '0;
      endcase
      if (!is64) r.imm[63:32] = '0;
    end
    return r;
  endfunction

  bit          mon_en = 1'b0;
  bit          m_rdy;
  bit          m_hs;
  sb_t         m_e;
  logic [31:0] m_count = '0;

  // Scoreboard monitor: handshake model, in-order delivery and counter tracking.
  always @(negedge clk) begin
    if (mon_en) begin
      m_rdy = !rst && !flush && (q.size() < 2);
      check_eq("in_ready32", if32.in_ready, m_rdy);
      check_eq("in_ready64", if64.in_ready, m_rdy);
      check_eq("out_valid32", if32.out_valid, q.size() > 0);
      check_eq("out_valid64", if64.out_valid, q.size() > 0);
      check_eq("count32", if32.decode_count, m_count);
      check_eq("count64", if64.decode_count, m_count);
      m_hs = out_ready && (q.size() > 0);
      if (m_hs) begin
        m_e = q.pop_front();
        check_eq("instr32", if32.out_instr, m_e.e32.f);
        check_eq("type32",  if32.out_type, m_e.e32.t);
        check_eq("imm32",   if32.out_imm, m_e.e32.imm);
        check_eq("ill32",   if32.out_illegal, m_e.e32.ill);
        check_eq("pc32",    if32.out_pc, {32'b0, m_e.pc[31:0]});
        check_eq("instr64", if64.out_instr, m_e.e64.f);
        check_eq("type64",  if64.out_type, m_e.e64.t);
        check_eq("imm64",   if64.out_imm, m_e.e64.imm);
        check_eq("ill64",   if64.out_illegal, m_e.e64.ill);
        check_eq("pc64",    if64.out_pc, m_e.pc);
      end
      if (in_valid && m_rdy) begin
        m_e.e32 = model(in_instr, 1'b0, 1'b1, 1'b1);
        m_e.e64 = model(in_instr, 1'b1, 1'b0, 1'b0);
        m_e.pc  = in_pc;
        q.push_back(m_e);
      end
      if (rst) m_count = '0;
      else if (m_hs) m_count = m_count + 32'd1;
      if (rst || flush) q.delete();
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid32"}, if32.out_valid, 0);
    check_eq({tag, "_count32"}, if32.decode_count, 0);
    check_eq({tag, "_imm32"},   if32.out_imm, 0);
    check_eq({tag, "_pc32"},    if32.out_pc, 0);
    check_eq({tag, "_instr32"}, if32.out_instr, 0);
    check_eq({tag, "_type32"},  if32.out_type, 0);
    check_eq({tag, "_ill32"},   if32.out_illegal, 0);
    check_eq({tag, "_valid64"}, if64.out_valid, 0);
    check_eq({tag, "_count64"}, if64.decode_count, 0);
    check_eq({tag, "_imm64"},   if64.out_imm, 0);
    check_eq({tag, "_pc64"},    if64.out_pc, 0);
  endtask

  // Single-cycle offer into an empty, non-stalled stage.
  task automatic send_one(input logic [31:0] w, input logic [63:0] pc);
    in_instr = w; in_pc = pc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Offer until accepted, with a bounded wait.
  task automatic offer(input logic [31:0] w, input logic [63:0] pc);
    bit acc;
    acc = 1'b0;
    in_instr = w; in_pc = pc; in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = if32.in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) check_eq("offer_timeout", 0, 1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [11];
    logic [31:0] r;
    int          k;
    ops = '{7'h03, 7'h0F, 7'h13, 7'h67, 7'h73, 7'h17, 7'h37, 7'h23, 7'h33, 7'h63, 7'h6F};
    r = $urandom;
    k = $urandom_range(0, 13);
    if (k < 11)       return {r[31:7], ops[k]};
    else if (k == 11) return {7'b0000001, r[24:7], 7'h33};
    else              return r;
  endfunction

  logic [31:0] c0;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    @(posedge clk);
    mon_en = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // addi x1,x2,-1
    send_one(32'hFFF10093, 64'h1000);
    @(negedge clk);
    check_eq("addi_valid", if32.out_valid, 1);
    check_eq("addi_imm32", if32.out_imm, 64'hFFFF_FFFF);
    check_eq("addi_rd",    if32.out_instr.rd, 1);
    check_eq("addi_rs1",   if32.out_instr.rs1, 2);
    check_eq("addi_f3",    if32.out_instr.funct3, 0);
    check_eq("addi_rs2",   if32.out_instr.rs2, 0);
    check_eq("addi_f7",    if32.out_instr.funct7, 0);
    @(negedge clk);
    check_eq("addi_count", if32.decode_count, 1);

    // beq x0,x0,-4
    send_one(32'hFE000EE3, 64'h1004);
    @(negedge clk);
    check_eq("beq_type64", if64.out_type, instr_type_SB);
    check_eq("beq_imm64",  if64.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    // lui x5,0x80000
    send_one(32'h800002B7, 64'h1008);
    @(negedge clk);
    check_eq("lui_imm64", if64.out_imm, 64'hFFFF_FFFF_8000_0000);
    check_eq("lui_imm32", if32.out_imm, 64'h8000_0000);
    // mul x3,x1,x2
    send_one(32'h022081B3, 64'h100C);
    @(negedge clk);
    check_eq("mul_ill64", if64.out_illegal, 1);
    check_eq("mul_imm64", if64.out_imm, 0);
    check_eq("mul_ill32", if32.out_illegal, 0);
    // nop with bits[1:0]=00
    send_one(32'h00000010, 64'h1010);
    @(negedge clk);
    check_eq("bad_ill32", if32.out_illegal, 1);
    check_eq("bad_ill64", if64.out_illegal, 1);
    // ecall
    send_one(32'h00000073, 64'h1014);
    @(negedge clk);
    check_eq("sys_ill64", if64.out_illegal, 1);
    check_eq("sys_ill32", if32.out_illegal, 0);
    repeat (2) @(posedge clk); #1;

    // Backpressure stream of four
    c0 = if32.decode_count;
    offer(32'h00500113, 64'h2000);
    out_ready = 1'b0;
    offer(32'h00208233, 64'h2004);
    in_instr = 32'h00312023; in_pc = 64'h2008; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("stall_in_ready", if32.in_ready, 0);
    check_eq("stall_hold_pc",  if32.out_pc, 64'h2000);
    @(posedge clk); #1;
    out_ready = 1'b1;
    offer(32'h00312023, 64'h2008);
    offer(32'h0080006F, 64'h200C);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("stream_count", if32.decode_count, c0 + 32'd4);
    @(posedge clk); #1;

    // Flush with both entries full and a new offer
    out_ready = 1'b0;
    offer(32'h00100093, 64'h3000);
    offer(32'h00200113, 64'h3004);
    in_instr = 32'h00300193; in_pc = 64'h3008; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_eq("flush_valid32", if32.out_valid, 0);
    check_eq("flush_valid64", if64.out_valid, 0);
    check_eq("flush_ready",   if32.in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    offer(32'h00400213, 64'h300C);
    repeat (3) @(posedge clk); #1;

    // Reset mid-stream with skid full
    out_ready = 1'b0;
    offer(32'h00500293, 64'h4000);
    offer(32'h00600313, 64'h4004);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;

    // Random traffic with occasional flush
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_instr  = rand_instr();
      in_pc     = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_eq("drain_empty", if32.out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode pipeline stage that replaces the purely combinational decoder between fetch and execute. Decodes one 32-bit RISC-V instruction per cycle, generates the XLEN-wide sign-extended immediate for every format and flags illegal encodings. Moves instructions through a 2-entry skid buffer with valid/ready handshakes on both sides. Also supports pipeline flush and keeps a handshake-counted decode counter.

## Interface
Parameters:
- XLEN, 32, datapath width (32 or 64); immediates and PC sign-extended/sized to XLEN
- ENABLE_M, 1, 0 makes OP-opcode instructions with funct7=7'b0000001 illegal
- ENABLE_PRIV, 1, 0 makes SYSTEM opcode (5'b11100) illegal

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all buffered instructions
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  stage accepts instruction this cycle
- in_instr  in  32  raw instruction (raw_instr_t)
- in_pc  in  XLEN  instruction address
- out_valid  out  1  decoded instruction available
- out_ready  in  1  execute consumes it this cycle
- out_instr  out  decoded_instr_t  opcode/rd/rs1/rs2/funct3/funct7
- out_type  out  instr_type_t  format
- out_imm  out  XLEN  sign-extended immediate
- out_pc  out  XLEN  forwarded in_pc
- out_illegal  out  1  illegal encoding
- decode_count  out  32  number of out handshakes, wraps modulo 2^32

## Operation
- Combinational decode of in_instr[6:2]:
  - I: 00000, 00011, 00100, 11001, 11100.
  - U: 00101, 01101.
  - S: 01000.
  - R: 01100.
  - SB: 11000.
  - UJ: 11011.
- Immediates:
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25],instr[11:7]}).
  - SB: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - UJ: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - U: sext({instr[31:12],12'b0}).
  - R: 0.
  - Sign extension is to XLEN; on XLEN=64, U is also sign-extended from bit 31.
- Fields not used by the format are driven 0, never X. opcode is always forwarded.
- out_illegal=1 when any of:
  - instr[1:0]!=2'b11
  - opcode not in the table
  - the ENABLE_M/ENABLE_PRIV rules above apply
- An illegal instruction is still passed downstream with out_illegal=1, out_imm=0, out_type=instr_type_I.
- Skid buffer holds a main entry and a skid entry.
  - in_ready = !skid_valid && !flush && !rst.
  - Accept (in_valid && in_ready):
    - main empty, or main draining this cycle → decoded result enters main;
    - otherwise → result enters skid.
  - Out handshake (out_valid && out_ready) with skid valid: skid moves to main in the same edge.
- Outputs are driven only from the main register. out_valid = main_valid.
- decode_count += 1 on each out handshake.

## Timing
- Reset (rst high at edge):
  - main_valid=0, skid_valid=0, all out_* data=0, out_illegal=0, decode_count=0.
  - in_ready=0 while rst is high; in_ready=1 in the first cycle after.
- Latency: instruction accepted at edge N appears on out_* in cycle N+1 when the main entry is free.
- Throughput: 1 instruction/cycle with out_ready held high.
- Backpressure:
  - out_ready low, main full, new accept → skid fills; in_ready=0 from the next cycle.
  - in_ready returns to 1 the cycle after the handshake that empties skid.
- No combinational path from out_ready to in_ready. in_ready depends only on registered skid_valid, flush and rst.
- out_* hold stable while out_valid && !out_ready.
- Flush at edge:
  - both entries invalidated; out_valid=0 next cycle;
  - any in_valid that cycle is not accepted;
  - an out handshake coincident with flush still counts in decode_count.
- Flush together with rst: reset wins; same outcome.
- decode_count wraps 0xFFFF_FFFF → 0.

## Structure
- Extend package Common with:
  - decode_pkt_t struct: decoded_instr_t, instr_type_t, imm, pc, illegal. The skid entries store this struct.
  - Opcode localparams, OPC_LOAD … OPC_SYSTEM.
  - Function imm_gen, parametrised via a width argument.
- One sub-module, decode_comb: a pure combinational raw→decode_pkt_t decoder taking XLEN/ENABLE_M/ENABLE_PRIV.
- decode_stage owns the skid buffer, flush and counter.

## Test plan
- addi x1,x2,-1 (0xFFF10093), XLEN=32, out_ready=1:
  - out_valid the next cycle;
  - out_imm=0xFFFFFFFF, rd=1, rs1=2, funct3=0, rs2=funct7=0;
  - decode_count=1.
- beq x0,x0,-4 (0xFE000EE3), XLEN=64: out_type=SB, out_imm=0xFFFFFFFFFFFFFFFC. lui x5,0x80000 (0x800002B7): out_imm=0xFFFFFFFF80000000.
- ENABLE_M=0, mul x3,x1,x2 (0x022081B3): out_illegal=1, out_imm=0. Instruction 0x00000013 with bits[1:0] forced to 00: out_illegal=1.
- Stream 4 instructions; hold out_ready=0 from cycle 2:
  - main and skid fill; in_ready=0;
  - release out_ready → all 4 delivered in order, no loss or duplication;
  - decode_count=4.
- Flush with both entries full and in_valid=1:
  - out_valid=0 next cycle;
  - the flushed instructions and the one offered in the flush cycle never appear;
  - in_ready=1 the cycle after flush.
- Assert rst mid-stream with skid full: all outputs at reset values next cycle; decode_count=0.
